fechadura_multiusuario: RTL and testbench

Parametrised lock-control core that replaces the single-password operational block: N user password slots, configurable password length, escalating lockout after repeated failures, timed auto-relock and a door-open alarm. It consumes the keypad decoder's digit stream and drives the bolt, the buzzer and status outputs for the display. Slot programming comes from the setup block over a valid/ready write port.

---
 rtl/fechadura_multiusuario.sv | 224 ++++++++++++++++++++++
 tb/tb_fechadura_multiusuario.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fechadura_multiusuario.sv
// Multi-user keypad lock: N password slots, escalating lockout,
// auto-relock, door-open alarm and a valid/ready slot write port.
//
// Ports:
//   clk, rst (async, active-low)
//   digit_valid/digit_value   keypad stream (0-9, A='*' clear, B='#' enter)
//   sensor_contato            1 = door closed
//   botao_interno             inside release button (rising edge acts)
//   prog_valid/prog_ready     slot write handshake
//   prog_user/senha/ativo     slot index, BCD password, enable bit
//   teclado_en, tranca, bip   keypad enable, bolt, buzzer
//   user_id, user_id_valid    slot that last opened the lock
//   bloqueado                 lockout active
//   tentativas_rest           remaining attempts
//   n_digitos                 digits buffered
module fechadura_multiusuario #(
  parameter int N_USERS = 4,
  parameter int DIGITS = 4,
  parameter int MAX_TRIES = 3,
  parameter int CYC_SEG = 50_000_000,
  parameter int LOCKOUT_S = 30,
  parameter int RELOCK_S = 5,
  parameter int ALARM_S = 10,
  parameter int BIP_LEN = 5_000_000,
  parameter logic [31:0] SENHA_PADRAO = 32'h0000_1234,
  localparam int UW = (N_USERS > 1) ? $clog2(N_USERS) : 1,
  localparam int PW = 4 * DIGITS,
  localparam int TW = $clog2(MAX_TRIES + 1),
  localparam int NW = $clog2(DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          digit_valid,
  input  logic [3:0]    digit_value,
  input  logic          sensor_contato,
  input  logic          botao_interno,
  input  logic          prog_valid,
  output logic          prog_ready,
  input  logic [UW-1:0] prog_user,
  input  logic [PW-1:0] prog_senha,
  input  logic          prog_ativo,
  output logic          teclado_en,
  output logic          tranca,
  output logic          bip,
  output logic [UW-1:0] user_id,
  output logic          user_id_valid,
  output logic          bloqueado,
  output logic [TW-1:0] tentativas_rest,
  output logic [NW-1:0] n_digitos
);

  typedef enum logic [2:0] {
    TRAVADO, VERIFICA, DESTRAVADO, PORTA_ABERTA, BLOQUEIO
  } state_t;

  state_t state, state_n;

  logic [PW-1:0] senha [N_USERS];
  logic [N_USERS-1:0] ativo;
  logic [PW-1:0] dbuf;
  logic [UW-1:0] vidx, hit_id;
  logic found;
  logic [31:0] presc, secs, beep_cnt;
  logic [3:0] mult;
  logic alarm;
  logic btn_s, btn_d;

  logic key_ok, is_num, is_clr, is_ent;
  logic rise, tick, full, cur_hit, last;
  logic lock_end, ok, fail, lock_exit, wr;

  assign key_ok = digit_valid && state == TRAVADO;
  assign is_num = key_ok && digit_value <= 4'd9;
  assign is_clr = key_ok && digit_value == 4'hA;
  assign is_ent = key_ok && digit_value == 4'hB;
  // Input is synchronised once, then edge-detected.
  assign rise = btn_s && !btn_d;
  assign tick = presc == 32'(CYC_SEG - 1);
  assign full = n_digitos == NW'(DIGITS);
  assign cur_hit = ativo[vidx] && senha[vidx] == dbuf && full;
  assign last = vidx == UW'(N_USERS - 1);
  assign lock_end = tick &&
    secs == 32'(LOCKOUT_S) * {28'd0, mult} - 32'd1;
  assign wr = prog_valid && prog_ready;

  assign prog_ready = state != VERIFICA;
  assign teclado_en = state == TRAVADO;
  assign bloqueado = state == BLOQUEIO;
  assign tranca = !(state == DESTRAVADO || state == PORTA_ABERTA);
  assign bip = beep_cnt != 0 ||
    (!sensor_contato && (state == TRAVADO || state == BLOQUEIO)) ||
    (state == PORTA_ABERTA && alarm);

  always_comb begin
    state_n = state;
    ok = 1'b0;
    fail = 1'b0;
    lock_exit = 1'b0;
    unique case (state)
      TRAVADO: begin
        if (rise) state_n = DESTRAVADO;
        else if (is_ent) state_n = VERIFICA;
      end
      VERIFICA: begin
        if (last) begin
          if (found || cur_hit) begin
            ok = 1'b1;
            state_n = DESTRAVADO;
          end else begin
            fail = 1'b1;
            state_n = (tentativas_rest == TW'(1)) ? BLOQUEIO : TRAVADO;
          end
        end
      end
      DESTRAVADO: begin
        if (!sensor_contato) state_n = PORTA_ABERTA;
        else if (tick && secs == 32'(RELOCK_S - 1)) state_n = TRAVADO;
      end
      PORTA_ABERTA: begin
        if (sensor_contato) state_n = TRAVADO;
      end
      BLOQUEIO: begin
        if (rise) state_n = DESTRAVADO;
        else if (lock_end) begin
          lock_exit = 1'b1;
          state_n = TRAVADO;
        end
      end
      default: state_n = TRAVADO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= TRAVADO;
      for (int i = 0; i < N_USERS; i++) senha[i] <= '0;
      senha[0] <= SENHA_PADRAO[PW-1:0];
      ativo <= '0;
      ativo[0] <= 1'b1;
      dbuf <= '0;
      n_digitos <= '0;
      vidx <= '0;
      hit_id <= '0;
      found <= 1'b0;
      presc <= '0;
      secs <= '0;
      beep_cnt <= '0;
      mult <= 4'd1;
      alarm <= 1'b0;
      btn_s <= 1'b0;
      btn_d <= 1'b0;
      user_id <= '0;
      user_id_valid <= 1'b0;
      tentativas_rest <= TW'(MAX_TRIES);
    end else begin
      state <= state_n;
      btn_s <= botao_interno;
      btn_d <= btn_s;

      if (state_n != state) begin
        presc <= '0;
        secs <= '0;
      end else if (tick) begin
        presc <= '0;
        secs <= secs + 32'd1;
      end else begin
        presc <= presc + 32'd1;
      end

      if (state_n != state) alarm <= 1'b0;
      else if (state == PORTA_ABERTA && tick &&
               secs == 32'(ALARM_S - 1)) alarm <= 1'b1;

      if (fail) beep_cnt <= 32'(BIP_LEN);
      else if (beep_cnt != 0) beep_cnt <= beep_cnt - 32'd1;

      if ((state == VERIFICA && last) || is_clr) begin
        dbuf <= '0;
        n_digitos <= '0;
      end else if (is_num) begin
        dbuf <= {dbuf[PW-5:0], digit_value};
        if (!full) n_digitos <= n_digitos + NW'(1);
      end

      if (state_n == VERIFICA && state != VERIFICA) begin
        vidx <= '0;
        found <= 1'b0;
      end else if (state == VERIFICA) begin
        if (cur_hit && !found) begin
          found <= 1'b1;
          hit_id <= vidx;
        end
        if (!last) vidx <= vidx + UW'(1);
      end

      if (ok) begin
        user_id <= found ? hit_id : vidx;
        user_id_valid <= 1'b1;
        tentativas_rest <= TW'(MAX_TRIES);
        mult <= 4'd1;
      end

      if (fail) begin
        if (tentativas_rest == TW'(1))
          tentativas_rest <= TW'(MAX_TRIES);
        else
          tentativas_rest <= tentativas_rest - TW'(1);
      end

      // Button exits leave the multiplier untouched.
      if (state_n == DESTRAVADO && state != VERIFICA &&
          state != DESTRAVADO)
        user_id_valid <= 1'b0;

      if (lock_exit) mult <= (mult == 4'd8) ? 4'd8 : mult << 1;

      if (wr && int'(prog_user) < N_USERS) begin
        senha[prog_user] <= prog_senha;
        ativo[prog_user] <= prog_ativo;
      end
    end
  end

endmodule

// File: tb/tb_fechadura_multiusuario.sv
// Directed bench for fechadura_multiusuario with hand-computed
// expectations at small timing parameters.
module tb_fechadura_multiusuario;

  localparam int NU = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic digit_valid = 1'b0;
  logic [3:0] digit_value = '0;
  logic sensor_contato = 1'b1;
  logic botao_interno = 1'b0;
  logic prog_valid = 1'b0;
  logic prog_ready;
  logic [1:0] prog_user = '0;
  logic [15:0] prog_senha = '0;
  logic prog_ativo = 1'b0;
  logic teclado_en, tranca, bip, user_id_valid, bloqueado;
  logic [1:0] user_id;
  logic [1:0] tentativas_rest;
  logic [2:0] n_digitos;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fechadura_multiusuario #(
    .N_USERS(NU), .DIGITS(4), .MAX_TRIES(3), .CYC_SEG(10),
    .LOCKOUT_S(2), .RELOCK_S(3), .ALARM_S(2), .BIP_LEN(4),
    .SENHA_PADRAO(32'h1234)
  ) dut (
    .clk(clk), .rst(rst),
    .digit_valid(digit_valid), .digit_value(digit_value),
    .sensor_contato(sensor_contato), .botao_interno(botao_interno),
    .prog_valid(prog_valid), .prog_ready(prog_ready),
    .prog_user(prog_user), .prog_senha(prog_senha),
    .prog_ativo(prog_ativo), .teclado_en(teclado_en),
    .tranca(tranca), .bip(bip), .user_id(user_id),
    .user_id_valid(user_id_valid), .bloqueado(bloqueado),
    .tentativas_rest(tentativas_rest), .n_digitos(n_digitos)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1;
    digit_value = d;
    cyc(1);
    digit_valid = 1'b0;
    digit_value = '0;
  endtask

  task automatic entra(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) key(code[4*i +: 4]);
    key(4'hB);
    cyc(NU);
  endtask

  task automatic porta();
    sensor_contato = 1'b0;
    cyc(1);
    sensor_contato = 1'b1;
    cyc(1);
  endtask

  task automatic erra3();
    repeat (3) entra(16'h0000);
  endtask

  initial begin
    cyc(2);
    chk("rst_tranca", tranca, 1);
    chk("rst_bip", bip, 0);
    chk("rst_uid", user_id, 0);
    chk("rst_uidv", user_id_valid, 0);
    chk("rst_bloq", bloqueado, 0);
    chk("rst_tent", tentativas_rest, 3);
    chk("rst_ndig", n_digitos, 0);
    chk("rst_tecl", teclado_en, 1);
    chk("rst_ready", prog_ready, 1);
    rst = 1'b1;
    cyc(1);

    // default password, timing of '#' and auto-relock
    key(4'd1);
    chk("ndig_1", n_digitos, 1);
    key(4'd2); key(4'd3); key(4'd4);
    chk("ndig_4", n_digitos, 4);
    key(4'hB);
    cyc(3);
    chk("verif_locked", tranca, 1);
    chk("verif_busy", prog_ready, 0);
    cyc(1);
    chk("def_open", tranca, 0);
    chk("def_uid", user_id, 0);
    chk("def_uidv", user_id_valid, 1);
    chk("def_clr", n_digitos, 0);
    cyc(29);
    chk("relock_29", tranca, 0);
    cyc(1);
    chk("relock_30", tranca, 1);

    // clear key
    key(4'd7);
    key(4'hA);
    chk("star_clr", n_digitos, 0);

    // programmed slot
    prog_valid = 1'b1; prog_user = 2'd2;
    prog_senha = 16'h5678; prog_ativo = 1'b1;
    cyc(1);
    prog_valid = 1'b0;
    key(4'd9);
    entra(16'h5678);
    chk("slot2_open", tranca, 0);
    chk("slot2_uid", user_id, 2);
    porta();
    chk("close_tranca", tranca, 1);

    // short entry fails
    key(4'd5); key(4'd6); key(4'd7); key(4'hB);
    cyc(NU);
    chk("short_bip", bip, 1);
    chk("short_tent", tentativas_rest, 2);
    chk("short_lock", tranca, 1);
    cyc(3);
    chk("bip_4th", bip, 1);
    cyc(1);
    chk("bip_end", bip, 0);

    // escalating lockout
    entra(16'h1234);
    chk("reopen", tranca, 0);
    chk("tent_reload", tentativas_rest, 3);
    porta();
    erra3();
    chk("lock1_on", bloqueado, 1);
    chk("lock1_tent", tentativas_rest, 3);
    chk("lock1_tecl", teclado_en, 0);
    key(4'd1);
    chk("lock1_ign", n_digitos, 0);
    cyc(18);
    chk("lock1_19", bloqueado, 1);
    cyc(1);
    chk("lock1_20", bloqueado, 0);
    erra3();
    cyc(39);
    chk("lock2_39", bloqueado, 1);
    cyc(1);
    chk("lock2_40", bloqueado, 0);
    entra(16'h1234);
    chk("mult_rst_open", tranca, 0);
    porta();
    erra3();
    cyc(19);
    chk("lock3_19", bloqueado, 1);
    cyc(1);
    chk("lock3_20", bloqueado, 0);

    // door alarm
    entra(16'h1234);
    sensor_contato = 1'b0;
    cyc(1);
    cyc(9);
    chk("alarm_10", bip, 0);
    cyc(13);
    chk("alarm_23", bip, 1);
    chk("alarm_open", tranca, 0);
    cyc(2);
    sensor_contato = 1'b1;
    cyc(1);
    chk("alarm_cl_tr", tranca, 1);
    chk("alarm_cl_bip", bip, 0);

    // intrusion while locked
    sensor_contato = 1'b0;
    cyc(1);
    chk("intrus_on", bip, 1);
    sensor_contato = 1'b1;
    cyc(1);
    chk("intrus_off", bip, 0);

    // button beats '#' during lockout
    erra3();
    botao_interno = 1'b1;
    digit_valid = 1'b1;
    digit_value = 4'hB;
    cyc(1);
    digit_valid = 1'b0;
    digit_value = '0;
    chk("btn_lat1", tranca, 1);
    cyc(1);
    chk("btn_open", tranca, 0);
    chk("btn_uidv", user_id_valid, 0);
    chk("btn_bloq", bloqueado, 0);
    botao_interno = 1'b0;
    porta();

    // write held during VERIFICA
    key(4'd0); key(4'd0); key(4'd0); key(4'd0); key(4'hB);
    prog_valid = 1'b1; prog_user = 2'd3;
    prog_senha = 16'h4321; prog_ativo = 1'b1;
    chk("wr_ready0", prog_ready, 0);
    cyc(3);
    chk("wr_ready0b", prog_ready, 0);
    cyc(1);
    chk("wr_ready1", prog_ready, 1);
    cyc(1);
    prog_valid = 1'b0;
    entra(16'h4321);
    chk("slot3_open", tranca, 0);
    chk("slot3_uid", user_id, 3);
    porta();

    // async reset mid-VERIFICA
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'hB);
    cyc(2);
    rst = 1'b0;
    #1;
    chk("arst_tranca", tranca, 1);
    chk("arst_ready", prog_ready, 1);
    chk("arst_uidv", user_id_valid, 0);
    chk("arst_uid", user_id, 0);
    chk("arst_tent", tentativas_rest, 3);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    entra(16'h5678);
    chk("arst_slot2", tranca, 1);
    chk("arst_s2tent", tentativas_rest, 2);
    entra(16'h1234);
    chk("arst_slot0", tranca, 0);
    chk("arst_s0uid", user_id, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
